// File: rtl/ps2_scancode_rx_if.sv
// PS/2 receiver bundle: keyboard pins in, decoded make-code report out.
// Ports: PS2CLK/PS2DATA (raw, async pins); SCANCODE[7:0], INTRPT, EXTENDED, FRAME_ERR.
// slave = the receiver, master = whoever drives the pins and consumes the report.
interface ps2_scancode_rx_if;
    logic       PS2CLK;
    logic       PS2DATA;
    logic [7:0] SCANCODE;
    logic       INTRPT;
    logic       EXTENDED;
    logic       FRAME_ERR;

    modport slave (
        input  PS2CLK,
        input  PS2DATA,
        output SCANCODE,
        output INTRPT,
        output EXTENDED,
        output FRAME_ERR
    );

    modport master (
        output PS2CLK,
        output PS2DATA,
        input  SCANCODE,
        input  INTRPT,
        input  EXTENDED,
        input  FRAME_ERR
    );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: deserializes 11-bit frames, strips E0/F0 prefixes, reports make codes.
// Latency: 2 sync + FILTER_LEN cycles pin-to-strobe, 1 cycle stop-strobe to SCANCODE/INTRPT.
// Backpressure: none; the keyboard cannot be stalled, a newer report overwrites SCANCODE.
// Ports: CLK, RST (async active-high), bus (slave modport of ps2_scancode_rx_if).
// Optional macro PS2_PARITY_CHECK_EN: when defined, bad parity/stop pulses FRAME_ERR and drops the byte.
module ps2_scancode_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000,
    parameter int INT_CYCLES  = 4
) (
    input  logic               CLK,
    input  logic               RST,
    ps2_scancode_rx_if.slave   bus
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    localparam int ICW = $clog2(INT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           strobe;

    state_t         state_q, state_d;
    logic [2:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [TCW-1:0] tmo_q, tmo_d;
    logic           ext_q, ext_d, brk_q, brk_d;
    logic [7:0]     sc_q, sc_d;
    logic           exto_q, exto_d;
    logic           int_q, int_d;
    logic [ICW-1:0] icnt_q, icnt_d;
    logic           err_q, err_d;
    logic           frame_ok;
    logic           report;
`ifdef PS2_PARITY_CHECK_EN
    logic           par_q, par_d;
`endif

    // Input conditioning: the filtered clock only moves after FILTER_LEN
    // consecutive samples disagree with it, so short glitches never strobe.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        strobe = filt_q & ~filt_d;
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        tmo_d    = tmo_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        sc_d     = sc_q;
        exto_d   = exto_q;
        int_d    = int_q;
        icnt_d   = icnt_q;
        err_d    = 1'b0;
        report   = 1'b0;
        frame_ok = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
        par_d    = par_q;
        frame_ok = dat_s2_q & (^{shreg_q, par_q});
`endif

        // Inter-edge watchdog only runs while a frame is in flight.
        if (strobe || state_q == S_IDLE) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (!strobe && state_q != S_IDLE && tmo_q == TCW'(TIMEOUT_CYC - 1)) begin
            // Partial byte is abandoned; prefix flags survive on purpose.
            state_d = S_IDLE;
            err_d   = 1'b1;
            tmo_d   = '0;
        end else if (strobe) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end
                end
                S_DATA: begin
                    shreg_d  = {dat_s2_q, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                    par_d = dat_s2_q;
`endif
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!frame_ok) begin
                        err_d = 1'b1;
                    end else if (shreg_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shreg_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else if (brk_q) begin
                        // Release code: swallow it and reset the prefix state.
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end else begin
                        report = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // INTRPT is stretched so a slower consumer clock always sees it;
        // a new report reloads the stretch so the line never dips.
        if (report) begin
            sc_d   = shreg_q;
            exto_d = ext_q;
            ext_d  = 1'b0;
            int_d  = 1'b1;
            icnt_d = ICW'(INT_CYCLES - 1);
        end else if (icnt_q != '0) begin
            icnt_d = icnt_q - 1'b1;
        end else begin
            int_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            tmo_q    <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            sc_q     <= '0;
            exto_q   <= 1'b0;
            int_q    <= 1'b0;
            icnt_q   <= '0;
            err_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_q    <= 1'b0;
`endif
        end else begin
            clk_s1_q <= bus.PS2CLK;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= bus.PS2DATA;
            dat_s2_q <= dat_s1_q;
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            tmo_q    <= tmo_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            sc_q     <= sc_d;
            exto_q   <= exto_d;
            int_q    <= int_d;
            icnt_q   <= icnt_d;
            err_q    <= err_d;
`ifdef PS2_PARITY_CHECK_EN
            par_q    <= par_d;
`endif
        end
    end

    assign bus.SCANCODE  = sc_q;
    assign bus.INTRPT    = int_q;
    assign bus.EXTENDED  = exto_q;
    assign bus.FRAME_ERR = err_q;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: directed frames, transaction-level expectation model.
// Latency: reports expected a few cycles after each stop edge; checked every cycle at negedge.
// Backpressure: none; frames are spaced so each report completes before the next frame.
module tb_ps2_scancode_rx;
    localparam int INT_CYC = 4;
    localparam int TO_CYC  = 1000;
    localparam int HALF    = 40;
    localparam int GAP     = 200;

    logic clk;
    logic rst;
    ps2_scancode_rx_if bus();

    ps2_scancode_rx #(
        .FILTER_LEN (8),
        .TIMEOUT_CYC(TO_CYC),
        .INT_CYCLES (INT_CYC)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expectation model: prefix flags, pending reports, expected error count.
    logic [8:0] exp_q[$];
    logic       m_ext_f = 1'b0;
    logic       m_brk   = 1'b0;
    int         m_err   = 0;
    logic [7:0] m_sc    = 8'h00;
    logic       m_ext   = 1'b0;

    // Observed activity.
    int   n_int    = 0;
    int   n_err    = 0;
    int   hi_len   = 0;
    logic prev_int = 1'b0;
    logic prev_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input logic flip_par);
        logic ok;
        ok = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
        ok = !flip_par;
`endif
        if (!ok) begin
            m_err++;
        end else if (b == 8'hE0) begin
            m_ext_f = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (m_brk) begin
            m_brk   = 1'b0;
            m_ext_f = 1'b0;
        end else begin
            exp_q.push_back({m_ext_f, b});
            m_ext_f = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Device-to-host frame: data changes while PS2CLK is high, sampled on the fall.
    task automatic send_frame(input logic [7:0] b, input logic flip_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.PS2DATA = bits[i];
            wait_cyc(HALF);
            bus.PS2CLK = 1'b0;
            wait_cyc(HALF);
            bus.PS2CLK = 1'b1;
        end
        bus.PS2DATA = 1'b1;
        wait_cyc(GAP);
    endtask

    task automatic full_frame(input logic [7:0] b, input logic flip_par);
        model_frame(b, flip_par);
        send_frame(b, flip_par, 11);
    endtask

    task automatic sync_check(input string tag);
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_errcnt"}, n_err, m_err);
        chk({tag, "_int_idle"}, bus.INTRPT, 0);
    endtask

    // Cycle-level compare against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_sc", bus.SCANCODE, 0);
            chk("rst_int", bus.INTRPT, 0);
            chk("rst_ext", bus.EXTENDED, 0);
            chk("rst_err", bus.FRAME_ERR, 0);
            m_sc     = 8'h00;
            m_ext    = 1'b0;
            prev_int = 1'b0;
            prev_err = 1'b0;
            hi_len   = 0;
        end else begin
            if (bus.INTRPT && !prev_int) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_int: got code %0h expected no report at %0t",
                             bus.SCANCODE, $time);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("int_code", bus.SCANCODE, e[7:0]);
                    chk("int_ext", bus.EXTENDED, e[8]);
                    m_sc  = e[7:0];
                    m_ext = e[8];
                end
                n_int++;
                hi_len = 1;
            end else begin
                chk("hold_sc", bus.SCANCODE, m_sc);
                chk("hold_ext", bus.EXTENDED, m_ext);
                if (bus.INTRPT) hi_len++;
                if (!bus.INTRPT && prev_int) chk("int_width", hi_len, INT_CYC);
            end
            if (bus.FRAME_ERR) begin
                chk("err_width", prev_err, 0);
                if (!prev_err) n_err++;
            end
            prev_int = bus.INTRPT;
            prev_err = bus.FRAME_ERR;
        end
    end

    initial begin
        int base_int;
        int base_err;
        rst         = 1'b1;
        bus.PS2CLK  = 1'b1;
        bus.PS2DATA = 1'b1;
        wait_cyc(5);
        chk("reset_sc", bus.SCANCODE, 8'h00);
        chk("reset_int", bus.INTRPT, 0);
        chk("reset_ext", bus.EXTENDED, 0);
        chk("reset_err", bus.FRAME_ERR, 0);
        rst = 1'b0;
        wait_cyc(20);

        // Plain make code.
        full_frame(8'h1C, 1'b0);
        sync_check("f1c");
        chk("f1c_sc", bus.SCANCODE, 8'h1C);
        chk("f1c_ext", bus.EXTENDED, 0);
        chk("f1c_nint", n_int, 1);
        chk("f1c_nerr", n_err, 0);

        // Extended make code, then a plain one clears EXTENDED.
        full_frame(8'hE0, 1'b0);
        full_frame(8'h75, 1'b0);
        sync_check("e075");
        chk("e075_sc", bus.SCANCODE, 8'h75);
        chk("e075_ext", bus.EXTENDED, 1);
        chk("e075_nint", n_int, 2);
        full_frame(8'h1C, 1'b0);
        sync_check("after_ext");
        chk("after_ext_ext", bus.EXTENDED, 0);
        chk("after_ext_nint", n_int, 3);

        // Make, break prefix, release: only the make reports.
        full_frame(8'h1C, 1'b0);
        full_frame(8'hF0, 1'b0);
        full_frame(8'h1C, 1'b0);
        sync_check("brk");
        chk("brk_nint", n_int, 4);
        chk("brk_sc", bus.SCANCODE, 8'h1C);
        full_frame(8'h29, 1'b0);
        sync_check("brk_clr");
        chk("brk_clr_nint", n_int, 5);
        chk("brk_clr_sc", bus.SCANCODE, 8'h29);

        // Wrong parity.
        full_frame(8'h1C, 1'b1);
        sync_check("par");
`ifdef PS2_PARITY_CHECK_EN
        chk("par_nint", n_int, 5);
        chk("par_nerr", n_err, 1);
        chk("par_sc", bus.SCANCODE, 8'h29);
`else
        chk("par_nint", n_int, 6);
        chk("par_nerr", n_err, 0);
        chk("par_sc", bus.SCANCODE, 8'h1C);
`endif

        // Abandoned frame after 5 data bits: watchdog fires, next frame is clean.
        base_err = n_err;
        base_int = n_int;
        m_err++;
        send_frame(8'h55, 1'b0, 6);
        wait_cyc(TO_CYC + 200);
        sync_check("tmo");
        chk("tmo_nerr", n_err, base_err + 1);
        chk("tmo_nint", n_int, base_int);
        full_frame(8'h29, 1'b0);
        sync_check("tmo_next");
        chk("tmo_next_sc", bus.SCANCODE, 8'h29);

        // 3-cycle PS2CLK glitch with data low: must not start a frame.
        base_err = n_err;
        base_int = n_int;
        bus.PS2DATA = 1'b0;
        bus.PS2CLK  = 1'b0;
        wait_cyc(3);
        bus.PS2CLK  = 1'b1;
        bus.PS2DATA = 1'b1;
        wait_cyc(TO_CYC + 100);
        chk("glitch_nerr", n_err, base_err);
        chk("glitch_nint", n_int, base_int);
        full_frame(8'h5A, 1'b0);
        sync_check("glitch_next");
        chk("glitch_next_sc", bus.SCANCODE, 8'h5A);
        chk("glitch_next_nint", n_int, base_int + 1);

        // Reset in the middle of a frame.
        full_frame(8'hE0, 1'b0);
        bus.PS2DATA = 1'b0;
        wait_cyc(HALF);
        bus.PS2CLK = 1'b0;
        wait_cyc(HALF);
        bus.PS2CLK = 1'b1;
        bus.PS2DATA = 1'b1;
        wait_cyc(HALF);
        bus.PS2CLK = 1'b0;
        wait_cyc(HALF);
        bus.PS2CLK = 1'b1;
        rst = 1'b1;
        wait_cyc(3);
        chk("midrst_sc", bus.SCANCODE, 8'h00);
        chk("midrst_int", bus.INTRPT, 0);
        exp_q.delete();
        m_ext_f = 1'b0;
        m_brk   = 1'b0;
        rst = 1'b0;
        wait_cyc(50);
        full_frame(8'h1C, 1'b0);
        sync_check("midrst_next");
        chk("midrst_next_sc", bus.SCANCODE, 8'h1C);
        chk("midrst_next_ext", bus.EXTENDED, 0);
`ifdef PS2_PARITY_CHECK_EN
        chk("total_nint", n_int, 8);
        chk("total_nerr", n_err, 2);
`else
        chk("total_nint", n_int, 9);
        chk("total_nerr", n_err, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
